// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared scan state encoding and grid size limit
package led_scan_pkg;
  localparam int MAX_N = 8;
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_e;
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: column-slot cycle counter, held at zero while clr is high
module scan_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  output logic [$clog2(PRESCALE)-1:0] count,
  output logic                        last
);
  localparam int CW = $clog2(PRESCALE);
  logic [CW-1:0] count_q, count_d;
  always_comb count_d = (clr || last) ? '0 : count_q + CW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
  assign last  = count_q == CW'(PRESCALE - 1);
endmodule

// File: rtl/led_scan_controller.sv
// led_scan_controller: column-multiplexed LED scanner with double-buffered frame loading
module led_scan_controller
  import led_scan_pkg::*;
#(
  parameter int N        = 5,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               frame_valid,
  input  logic [N*N-1:0]     frame_data,
  output logic               frame_ready,
  output logic               frame_done,
  output logic               ena,
  output logic [$clog2(N):0] x,
  output logic [N*N-1:0]     cells
);
  localparam int CW = $clog2(PRESCALE);
  localparam int XW = $clog2(N) + 1;
  if (N < 1 || N > MAX_N) begin : g_bad_n
    $error("led_scan_controller: N=%0d outside 1..%0d", N, MAX_N);
  end
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("led_scan_controller: PRESCALE=%0d must be at least 2", PRESCALE);
  end
  if (BLANK < 1 || BLANK > PRESCALE - 1) begin : g_bad_blank
    $error("led_scan_controller: BLANK=%0d outside 1..PRESCALE-1", BLANK);
  end
  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [N*N-1:0] cells_q, cells_d, pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic [CW-1:0] count;
  logic          last, slot_end, boundary, accept;
  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == S_IDLE || !run),
    .count(count),
    .last (last)
  );
  always_comb begin
    slot_end    = run && state_q == S_ON && last;
    boundary    = slot_end && x_q == XW'(N - 1);
    accept      = frame_valid && !pend_full_q;
    state_d     = state_q;
    case (state_q)
      S_IDLE:  state_d = S_BLANK;
      S_BLANK: state_d = count == CW'(BLANK - 1) ? S_ON : S_BLANK;
      S_ON:    state_d = last ? S_BLANK : S_ON;
      default: state_d = S_IDLE;
    endcase
    if (!run) state_d = S_IDLE;
    x_d         = !run ? '0 : !slot_end ? x_q : boundary ? '0 : x_q + XW'(1);
    pend_d      = accept ? frame_data : pend_q;
    // a frame accepted on the boundary cycle lands in pending, not cells
    pend_full_d = accept || (pend_full_q && !boundary);
    cells_d     = (boundary && pend_full_q) ? pend_q : cells_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      cells_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      cells_q     <= cells_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  assign ena         = state_q == S_ON;
  assign x           = x_q;
  assign frame_ready = !pend_full_q;
  assign frame_done  = boundary;
  assign cells       = cells_q;
endmodule

// File: tb/tb_led_scan_controller.sv
// tb_led_scan_controller: directed vector checks of the LED scan controller
module tb_led_scan_controller;
  typedef struct {
    logic        run;
    logic        fv;
    logic [24:0] fd;
    logic        ena;
    logic [3:0]  x;
    logic        done;
    logic        ready;
    logic [24:0] cells;
  } vec_t;
  logic        clk, rst_n, run, frame_valid, frame_ready, frame_done, ena;
  logic [24:0] frame_data, cells;
  logic [3:0]  x;
  logic        run1, frame_ready1, frame_done1, ena1;
  logic [0:0]  x1, cells1;
  int          passed = 0, total = 0;
  vec_t        tbl[84];
  led_scan_controller #(.N(5), .PRESCALE(4), .BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_ready(frame_ready), .frame_done(frame_done), .ena(ena), .x(x), .cells(cells)
  );
  led_scan_controller #(.N(1), .PRESCALE(2), .BLANK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .run(run1), .frame_valid(1'b0), .frame_data(1'b0),
    .frame_ready(frame_ready1), .frame_done(frame_done1), .ena(ena1), .x(x1), .cells(cells1)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic cyc(input logic r, input logic v, input logic [24:0] d);
    @(negedge clk);
    run = r; frame_valid = v; frame_data = d;
    #1;
  endtask
  task automatic chk_all(input string tag, input logic e, input logic [3:0] xx, input logic dn,
                         input logic rd, input logic [24:0] c);
    chk({tag, " ena"}, 32'(ena), 32'(e));
    chk({tag, " x"}, 32'(x), 32'(xx));
    chk({tag, " frame_done"}, 32'(frame_done), 32'(dn));
    chk({tag, " frame_ready"}, 32'(frame_ready), 32'(rd));
    chk({tag, " cells"}, 32'(cells), 32'(c));
  endtask
  initial begin
    rst_n = 1'b0; run = 1'b0; run1 = 1'b0; frame_valid = 1'b0; frame_data = '0;
    for (int k = 0; k < 84; k++) begin
      tbl[k].run   = 1'b1;
      tbl[k].fv    = k == 5 || (k >= 10 && k <= 20) || k == 59;
      tbl[k].fd    = k == 5 ? 25'h1555555 : (k >= 10 && k <= 20) ? 25'h0AAAAAA
                   : k == 59 ? 25'h1234567 : 25'h1FFFFFF;
      tbl[k].ena   = k % 4 != 0;
      tbl[k].x     = 4'((k / 4) % 5);
      tbl[k].done  = k % 20 == 19;
      tbl[k].ready = k <= 5 || k == 20 || (k >= 40 && k <= 59) || k >= 80;
      tbl[k].cells = k < 20 ? 25'h0 : k < 40 ? 25'h1555555 : k < 80 ? 25'h0AAAAAA : 25'h1234567;
    end
    cyc(0, 0, '0);
    chk_all("reset", 0, 0, 0, 1, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, '0);
      chk_all($sformatf("idle%0d", i), 0, 0, 0, 1, 0);
    end
    cyc(1, 0, '0);
    chk_all("run_start", 0, 0, 0, 1, 0);
    for (int k = 0; k < 84; k++) begin
      cyc(tbl[k].run, tbl[k].fv, tbl[k].fd);
      chk_all($sformatf("scan k=%0d", k), tbl[k].ena, tbl[k].x, tbl[k].done, tbl[k].ready, tbl[k].cells);
    end
    for (int k = 84; k < 89; k++) cyc(1, 0, '0);
    cyc(0, 0, '0);
    chk_all("stop_cycle", 1, 2, 0, 1, 25'h1234567);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, '0);
      chk_all($sformatf("stopped%0d", i), 0, 0, 0, 1, 25'h1234567);
    end
    cyc(0, 1, 25'h0F0F0F0);
    chk_all("idle_offer", 0, 0, 0, 1, 25'h1234567);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 25'h1FFFFFF);
      chk_all($sformatf("idle_held%0d", i), 0, 0, 0, 0, 25'h1234567);
    end
    cyc(1, 0, '0);
    chk_all("restart", 0, 0, 0, 0, 25'h1234567);
    for (int k = 0; k <= 20; k++) begin
      cyc(1, 0, 25'h1FFFFFF);
      chk_all($sformatf("restart k=%0d", k), k % 4 != 0, 4'((k / 4) % 5), k == 19, k == 20,
              k < 20 ? 25'h1234567 : 25'h0F0F0F0);
    end
    cyc(1, 1, 25'h1FFFFFF);
    chk("pre_rst ready", 32'(frame_ready), 1);
    cyc(1, 0, '0);
    chk("pre_rst pending", 32'(frame_ready), 0);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 1, 0);
    @(negedge clk) begin rst_n = 1'b1; run = 1'b0; end
    cyc(1, 0, '0);
    chk_all("post_rst_start", 0, 0, 0, 1, 0);
    for (int k = 0; k <= 21; k++) begin
      cyc(1, 0, '0);
      chk_all($sformatf("post_rst k=%0d", k), k % 4 != 0, 4'((k / 4) % 5), k == 19, 1, 0);
    end
    cyc(0, 0, '0);
    @(negedge clk) run1 = 1'b1;
    #1;
    chk("n1 idle ena", 32'(ena1), 0);
    chk("n1 idle done", 32'(frame_done1), 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("n1 ena k=%0d", k), 32'(ena1), 32'(k % 2));
      chk($sformatf("n1 x k=%0d", k), 32'(x1), 0);
      chk($sformatf("n1 done k=%0d", k), 32'(frame_done1), 32'(k % 2));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
